// File: rtl/seq_divider_if.sv
// Operand/result handshake bundle for seq_divider: valid/ready on the operand side and on the result side.
interface seq_divider_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;
    logic             overflow;
    logic             busy;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero, overflow, busy
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero, overflow, busy
    );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with Euclidean sign fix-up (quotient, non-negative remainder).
// Optional DIV_EARLY_EXIT_EN: bypass the iteration when b == 0 or |a| < |b|.
module seq_divider #(
    parameter int WIDTH  = 16,
    parameter bit SIGNED = 1'b1
) (
    input logic          clk,
    input logic          reset,
    seq_divider_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [CW-1:0]    r_cnt;
    logic             r_a_neg;
    logic             r_b_neg;
    logic             r_b_zero;
    logic             r_ovf_case;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_div;

    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rmd;
    logic             r_dz;
    logic             r_ov;
    logic             r_out_valid;

    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_ovf_case;
    logic             w_early;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_sub;
    logic             w_ge;
    logic [2*WIDTH+1:0] w_fix;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + 1'b1;
    endfunction

    // Maps the unsigned magnitude result (q0, r0) onto Euclidean signed results.
    // Packed as {div_zero, overflow, quotient, remainder}.
    function automatic logic [2*WIDTH+1:0] fix_result(
        input logic             a_neg,
        input logic             b_neg,
        input logic             b_zero,
        input logic             ovf,
        input logic [WIDTH-1:0] q0,
        input logic [WIDTH-1:0] r0,
        input logic [WIDTH-1:0] bmag
    );
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic [WIDTH-1:0] q_inc;
        logic             dz;
        logic             ov;
        q     = q0;
        r     = r0;
        dz    = 1'b0;
        ov    = 1'b0;
        q_inc = q0 + 1'b1;
        if (b_zero) begin
            q  = '0;
            r  = SIGNED ? {1'b0, {(WIDTH-1){1'b1}}} : {WIDTH{1'b1}};
            dz = 1'b1;
        end else if (ovf) begin
            q  = MOST_NEG;
            r  = '0;
            ov = 1'b1;
        end else if (!a_neg) begin
            q = b_neg ? negate(q0) : q0;
            r = r0;
        end else if (r0 == '0) begin
            q = b_neg ? q0 : negate(q0);
            r = '0;
        end else begin
            q = b_neg ? q_inc : negate(q_inc);
            r = bmag - r0;
        end
        return {dz, ov, q, r};
    endfunction

    assign w_a_neg    = SIGNED && bus.dividend[WIDTH-1];
    assign w_b_neg    = SIGNED && bus.divisor[WIDTH-1];
    assign w_a_mag    = w_a_neg ? negate(bus.dividend) : bus.dividend;
    assign w_b_mag    = w_b_neg ? negate(bus.divisor) : bus.divisor;
    assign w_ovf_case = SIGNED && (bus.dividend == MOST_NEG) && (bus.divisor == {WIDTH{1'b1}});

`ifdef DIV_EARLY_EXIT_EN
    assign w_early = (bus.divisor == '0) || (w_a_mag < w_b_mag);
`else
    assign w_early = 1'b0;
`endif

    // Restoring step: the remainder shifted left with the next dividend bit needs WIDTH+1 bits.
    assign w_shift = {r_rem, r_q[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, r_div});
    assign w_sub   = w_shift[WIDTH-1:0] - r_div;

    assign w_fix = fix_result(r_a_neg, r_b_neg, r_b_zero, r_ovf_case, r_q, r_rem, r_div);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    w_state_nxt = w_early ? FIX : CALC;
                end
            end
            CALC: begin
                if (r_cnt == CW'(1)) begin
                    w_state_nxt = FIX;
                end
            end
            FIX: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Operand capture and iteration datapath; no reset needed since IDLE always reloads it.
    always_ff @(posedge clk) begin
        case (r_state)
            IDLE: begin
                if (bus.in_valid) begin
                    r_a_neg    <= w_a_neg;
                    r_b_neg    <= w_b_neg;
                    r_b_zero   <= (bus.divisor == '0);
                    r_ovf_case <= w_ovf_case;
                    r_div      <= w_b_mag;
                    if (w_early) begin
                        r_q   <= '0;
                        r_rem <= w_a_mag;
                    end else begin
                        r_q   <= w_a_mag;
                        r_rem <= '0;
                    end
                end
            end
            CALC: begin
                r_rem <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                r_q   <= {r_q[WIDTH-2:0], w_ge};
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == IDLE && bus.in_valid) begin
            r_cnt <= CW'(WIDTH);
        end else if (r_state == CALC) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Result registers: loaded in FIX, held through DONE and afterwards until the next FIX.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_quot      <= '0;
            r_rmd       <= '0;
            r_dz        <= 1'b0;
            r_ov        <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (r_state == FIX) begin
            r_dz        <= w_fix[2*WIDTH+1];
            r_ov        <= w_fix[2*WIDTH];
            r_quot      <= w_fix[2*WIDTH-1:WIDTH];
            r_rmd       <= w_fix[WIDTH-1:0];
            r_out_valid <= 1'b1;
        end else if (r_state == DONE && bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = (r_state == IDLE);
    assign bus.busy      = (r_state != IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.quotient  = r_quot;
    assign bus.remainder = r_rmd;
    assign bus.div_zero  = r_dz;
    assign bus.overflow  = r_ov;

endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed bench for seq_divider against an integer-arithmetic Euclidean reference.
module tb_seq_divider;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;

    seq_divider_if #(.WIDTH(16)) bus16 ();
    seq_divider_if #(.WIDTH(8))  bus8 ();

    seq_divider #(.WIDTH(16), .SIGNED(1'b1)) dut16 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus16.slave)
    );

    seq_divider #(.WIDTH(8), .SIGNED(1'b0)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Euclidean reference: truncating division, then shift r into [0, |b|).
    function automatic void model16(input longint a, input longint b,
                                    output longint q, output longint r,
                                    output bit dz, output bit ov);
        dz = 1'b0;
        ov = 1'b0;
        if (b == 0) begin
            q  = 0;
            r  = 32767;
            dz = 1'b1;
        end else begin
            q = a / b;
            r = a - q * b;
            if (r < 0) begin
                if (b > 0) q = q - 1;
                else       q = q + 1;
                r = r + ((b > 0) ? b : -b);
            end
            ov = (a == -32768) && (b == -1);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run16(input logic [15:0] a, input logic [15:0] b, input int hold, input bit pulse);
        longint q, r;
        bit     dz, ov, irlow, stable;
        int     lat;
        logic [63:0] q16, r16;
        model16(longint'($signed(a)), longint'($signed(b)), q, r, dz, ov);
        q16 = {48'd0, q[15:0]};
        r16 = {48'd0, r[15:0]};
        bus16.dividend = a;
        bus16.divisor  = b;
        bus16.in_valid = 1'b1;
        tick();
        if (pulse) begin
            bus16.dividend = a ^ 16'h5a5a;
            bus16.divisor  = b + 16'd3;
        end else begin
            bus16.in_valid = 1'b0;
        end
        lat   = 0;
        irlow = 1'b1;
        while (!bus16.out_valid && lat < 200) begin
            if (bus16.in_ready) irlow = 1'b0;
            tick();
            lat++;
        end
        bus16.in_valid = 1'b0;
        check("latency", lat, 17);
        check("in_ready_calc", irlow, 1);
        check("in_ready_done", bus16.in_ready, 0);
        check("quotient", bus16.quotient, q16);
        check("remainder", bus16.remainder, r16);
        check("div_zero", bus16.div_zero, dz);
        check("overflow", bus16.overflow, ov);
        stable = 1'b1;
        repeat (hold) begin
            tick();
            if (!bus16.out_valid || bus16.in_ready || bus16.quotient !== q16[15:0] ||
                bus16.remainder !== r16[15:0]) stable = 1'b0;
        end
        if (hold > 0) check("hold_stable", stable, 1);
        bus16.out_ready = 1'b1;
        tick();
        bus16.out_ready = 1'b0;
        check("idle_in_ready", bus16.in_ready, 1);
        check("idle_out_valid", bus16.out_valid, 0);
        check("idle_busy", bus16.busy, 0);
        check("flags_retained", {bus16.div_zero, bus16.overflow}, {dz, ov});
    endtask

    task automatic run8(input logic [7:0] a, input logic [7:0] b);
        int lat;
        int q, r;
        if (b == 0) begin
            q = 0;
            r = 255;
        end else begin
            q = int'(a) / int'(b);
            r = int'(a) % int'(b);
        end
        bus8.dividend = a;
        bus8.divisor  = b;
        bus8.in_valid = 1'b1;
        tick();
        bus8.in_valid = 1'b0;
        lat = 0;
        while (!bus8.out_valid && lat < 100) begin
            tick();
            lat++;
        end
        check("w8_latency", lat, 9);
        check("w8_quotient", bus8.quotient, q);
        check("w8_remainder", bus8.remainder, r);
        check("w8_div_zero", bus8.div_zero, (b == 0));
        bus8.out_ready = 1'b1;
        tick();
        bus8.out_ready = 1'b0;
        check("w8_idle", bus8.in_ready, 1);
    endtask

    initial begin
        logic [15:0] ra, rb;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        bus16.in_valid = 1'b0; bus16.out_ready = 1'b0;
        bus16.dividend = '0;   bus16.divisor   = '0;
        bus8.in_valid  = 1'b0; bus8.out_ready  = 1'b0;
        bus8.dividend  = '0;   bus8.divisor    = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_in_ready", bus16.in_ready, 1);
        check("rst_out_valid", bus16.out_valid, 0);
        check("rst_busy", bus16.busy, 0);
        check("rst_outputs", {bus16.quotient, bus16.remainder, bus16.div_zero, bus16.overflow}, 0);

        run16(16'd42, 16'd7, 0, 1'b0);
        run16(-16'sd7, 16'd2, 0, 1'b0);
        run16(16'd7, -16'sd2, 0, 1'b0);
        run16(-16'sd7, -16'sd2, 0, 1'b0);
        run16(-16'sd42, 16'd7, 0, 1'b0);
        run16(16'd3, 16'd4, 0, 1'b0);
        run16(16'd0, -16'sd3, 0, 1'b0);
        run16(16'd0, 16'd0, 0, 1'b0);
        run16(16'd1, 16'd0, 0, 1'b0);
        run16(16'h8000, 16'hffff, 0, 1'b0);
        run16(16'h8000, 16'd7, 0, 1'b0);
        run16(16'h7fff, 16'h8000, 0, 1'b0);
        run16(16'd1234, 16'd17, 10, 1'b1);

        // Abort mid-iteration: no result may appear and all outputs return to zero.
        bus16.dividend = 16'd1000;
        bus16.divisor  = 16'd3;
        bus16.in_valid = 1'b1;
        tick();
        bus16.in_valid = 1'b0;
        repeat (8) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_out_valid", bus16.out_valid, 0);
        check("abort_in_ready", bus16.in_ready, 1);
        check("abort_busy", bus16.busy, 0);
        check("abort_outputs", {bus16.quotient, bus16.remainder, bus16.div_zero, bus16.overflow}, 0);
        tick();
        check("abort_no_result", bus16.out_valid, 0);
        run16(16'd26, 16'd7, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb = 16'($signed($urandom_range(0, 20)) - 10);
                1: rb = 16'($urandom_range(0, 300));
                2: rb = 16'($urandom);
                default: rb = -16'($urandom_range(1, 300));
            endcase
            if ($urandom_range(0, 9) == 0) ra = 16'h8000;
            run16(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        run8(8'd200, 8'd7);
        run8(8'd13, 8'd0);
        run8(8'd255, 8'd255);
        for (int i = 0; i < 10; i++) begin
            run8(8'($urandom), 8'($urandom_range(0, 255)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
